vga_sync_gen: RTL and testbench

Timing generator that drives the VGA connector and feeds pixel coordinates to the graphics pipeline. From the 50 MHz system clock it derives a pixel-enable tick and maintains horizontal and vertical scan counters. It produces active-low hsync/vsync, a `video_on` display-area flag and `pix_x`/`pix_y`. The graphics, text and score renderers consume these and return RGB for the same coordinate.

---
 rtl/vga_sync_gen.sv | 112 +++++++++++
 tb/tb_vga_sync_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA scan timing: pixel-enable divider, h/v scan counters, registered sync/blank decode.
// Defining VGA_SYNC_FRAME_CNT_EN adds the frame_start pulse and the 16-bit frame_cnt outputs.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        p_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;
  logic [9:0]       h_next;
  logic [9:0]       v_next;

  // With CLK_DIV = 1 the divider stays at 0 and the tick is permanently high.
  assign p_tick = (div_cnt == DIV_LAST);
  assign h_last = (pix_x == H_LAST);
  assign v_last = (pix_y == V_LAST);

  always_comb begin
    h_next = pix_x;
    v_next = pix_y;
    if (p_tick) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : pix_y + 10'd1;
      end else begin
        h_next = pix_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (p_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Sync and blank flags decode the next coordinate so they line up with pix_x/pix_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x    <= '0;
      pix_y    <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      pix_x    <= h_next;
      pix_y    <= v_next;
      hsync    <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync    <= !((v_next >= VS_START) && (v_next <= VS_END));
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic frame_wrap;

  assign frame_wrap = p_tick && h_last && v_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing scan scoreboard, a reduced-timing instance for
// frame-level behaviour and mid-scan reset, and a CLK_DIV = 1 instance.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int W    = 47;
  localparam int NPIX = 3 * 800 + 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;

  logic d_p_tick, d_hsync, d_vsync, d_video_on;
  logic [9:0] d_pix_x, d_pix_y;
  logic s_p_tick, s_hsync, s_vsync, s_video_on;
  logic [9:0] s_pix_x, s_pix_y;
  logic f_p_tick, f_hsync, f_vsync, f_video_on;
  logic [9:0] f_pix_x, f_pix_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic d_frame_start, s_frame_start, f_frame_start;
  logic [15:0] d_frame_cnt, s_frame_cnt, f_frame_cnt;
`endif

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  vga_sync_gen u_d (
    .clk(clk), .reset(rst), .p_tick(d_p_tick), .hsync(d_hsync), .vsync(d_vsync),
    .video_on(d_video_on), .pix_x(d_pix_x), .pix_y(d_pix_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_s (
    .clk(clk), .reset(rst_s), .p_tick(s_p_tick), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .pix_x(s_pix_x), .pix_y(s_pix_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
`endif
  );

  vga_sync_gen #(.CLK_DIV(1)) u_f (
    .clk(clk), .reset(rst), .p_tick(f_p_tick), .hsync(f_hsync), .vsync(f_vsync),
    .video_on(f_video_on), .pix_x(f_pix_x), .pix_y(f_pix_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_start(f_frame_start), .frame_cnt(f_frame_cnt)
`endif
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cyc %0d)", name, cyc);
  endtask

  // Expected state of the default-timing instance once coordinate k is on the outputs.
  function automatic logic [W-1:0] exp_entry(input int k);
    int x, y, c;
    logic hs, vs, vo;
    x = k % 800;
    y = (k / 800) % 525;
    c = k * 2;
    hs = !(x >= 656 && x <= 751);
    vs = !(y >= 490 && y <= 491);
    vo = (x < 640) && (y < 480);
    return {c[23:0], x[9:0], y[9:0], hs, vs, vo};
  endfunction

  // monitor state
  logic [9:0] mon_px, mon_py;
  logic [W-1:0] mon_act, mon_exp;
  int mon_seen, mon_guard;
  // line measurements
  int dl_hs_low, dl_hs_first, dl_vo_fall;
  logic dl_vo_prev;
  // small-instance measurements
  int s_vs_low, s_vs_first_y, s_vs_first_x, s_vo_cnt, s_vo_bad, s_wraps, s_w1, s_w2, s_fs_cnt;
  int s_guard;
  logic [9:0] s_py_prev;
  // CLK_DIV = 1 measurements
  int f_p0, f_w1, f_w2, f_hs;
  logic [9:0] f_px_prev;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_d_pix_x", d_pix_x, 0);
    check("rst_d_pix_y", d_pix_y, 0);
    check("rst_d_hsync", d_hsync, 1);
    check("rst_d_vsync", d_vsync, 1);
    check("rst_d_video_on", d_video_on, 1);
    check("rst_d_p_tick", d_p_tick, 0);
    check("rst_f_p_tick", f_p_tick, 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("rst_s_frame_start", s_frame_start, 0);
    check("rst_s_frame_cnt", s_frame_cnt, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst_s = 1'b0;

    fork
      begin : producer
        for (int k = 1; k <= NPIX; k++) exp_q.push_back(exp_entry(k));
      end

      begin : d_monitor
        mon_seen = 0;
        mon_guard = 0;
        mon_px = d_pix_x;
        mon_py = d_pix_y;
        while (mon_seen < NPIX && mon_guard < NPIX * 2 + 100) begin
          @(negedge clk);
          mon_guard++;
          if (cyc < 40) check("d_p_tick", d_p_tick, (cyc % 2) == 1);
          if (d_pix_x !== mon_px || d_pix_y !== mon_py) begin
            mon_act = {cyc[23:0], d_pix_x, d_pix_y, d_hsync, d_vsync, d_video_on};
            if (exp_q.size() == 0) begin
              fail_now("d_scan_unexpected_change");
            end else begin
              mon_exp = exp_q.pop_front();
              check("d_scan", mon_act, mon_exp);
            end
            mon_seen++;
            mon_px = d_pix_x;
            mon_py = d_pix_y;
          end
        end
        if (mon_seen < NPIX) fail_now("d_scan_timeout");
      end

      begin : d_line
        dl_hs_low = 0;
        dl_hs_first = -1;
        dl_vo_fall = -1;
        dl_vo_prev = 1'b1;
        for (int i = 1; i <= 1600; i++) begin
          @(negedge clk);
          if (!d_hsync) begin
            dl_hs_low++;
            if (dl_hs_first < 0) dl_hs_first = int'(d_pix_x);
          end
          if (dl_vo_prev && !d_video_on && dl_vo_fall < 0) dl_vo_fall = int'(d_pix_x);
          dl_vo_prev = d_video_on;
        end
        check("d_hsync_low_clks", dl_hs_low, 192);
        check("d_hsync_start_x", dl_hs_first, 656);
        check("d_video_on_fall_x", dl_vo_fall, 640);
        check("d_line_wrap_x", d_pix_x, 0);
        check("d_line_wrap_y", d_pix_y, 1);
      end

      begin : f_div1
        f_p0 = 0;
        f_w1 = -1;
        f_w2 = -1;
        f_hs = -1;
        f_px_prev = f_pix_x;
        for (int i = 1; i <= 1700; i++) begin
          @(negedge clk);
          if (!f_p_tick) f_p0++;
          if (f_px_prev == 10'd799 && f_pix_x == 10'd0) begin
            if (f_w1 < 0) f_w1 = cyc;
            else if (f_w2 < 0) f_w2 = cyc;
          end
          if (!f_hsync && f_hs < 0) f_hs = int'(f_pix_x);
          f_px_prev = f_pix_x;
        end
        check("f_p_tick_low_clks", f_p0, 0);
        check("f_first_wrap_cyc", f_w1, 800);
        check("f_line_period", f_w2 - f_w1, 800);
        check("f_hsync_start_x", f_hs, 656);
      end

      begin : s_frames
        s_vs_low = 0;
        s_vs_first_y = -1;
        s_vs_first_x = -1;
        s_vo_cnt = 0;
        s_vo_bad = 0;
        s_wraps = 0;
        s_w1 = -1;
        s_w2 = -1;
        s_fs_cnt = 0;
        s_py_prev = s_pix_y;
        for (int i = 1; i <= 2260; i++) begin
          @(negedge clk);
          if (i <= 750) begin
            if (!s_vsync) begin
              s_vs_low++;
              if (s_vs_first_y < 0) begin
                s_vs_first_y = int'(s_pix_y);
                s_vs_first_x = int'(s_pix_x);
              end
            end
            if (s_video_on) begin
              s_vo_cnt++;
              if (s_pix_y >= 10'd8) s_vo_bad++;
            end
          end
          if (s_py_prev == 10'd14 && s_pix_y == 10'd0) begin
            s_wraps++;
            if (s_wraps == 1) s_w1 = cyc;
            else if (s_wraps == 2) s_w2 = cyc;
          end
          s_py_prev = s_pix_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
          if (s_frame_start) begin
            s_fs_cnt++;
            check("s_frame_start_cyc", cyc, 750 * s_fs_cnt);
          end
`endif
        end
        check("s_vsync_low_clks", s_vs_low, 100);
        check("s_vsync_start_y", s_vs_first_y, 10);
        check("s_vsync_start_x", s_vs_first_x, 0);
        check("s_video_on_clks", s_vo_cnt, 256);
        check("s_video_on_in_vblank", s_vo_bad, 0);
        check("s_first_frame_wrap_cyc", s_w1, 750);
        check("s_frame_period", s_w2 - s_w1, 750);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("s_frame_start_count", s_fs_cnt, 3);
        check("s_frame_cnt_after_3", s_frame_cnt, 3);
        @(negedge clk);
        force u_s.frame_cnt = 16'hffff;
        @(negedge clk);
        release u_s.frame_cnt;
        @(negedge clk);
        check("s_frame_cnt_preload", s_frame_cnt, 16'hffff);
        s_guard = 0;
        while (!s_frame_start && s_guard < 800) begin
          @(negedge clk);
          s_guard++;
        end
        if (!s_frame_start) fail_now("s_frame_start_timeout");
        check("s_frame_cnt_wrap", s_frame_cnt, 0);
`endif
        // mid-scan asynchronous reset, asserted between clock edges
        s_guard = 0;
        while (!(s_pix_x == 10'd10 && s_pix_y == 10'd5) && s_guard < 800) begin
          @(negedge clk);
          s_guard++;
        end
        if (!(s_pix_x == 10'd10 && s_pix_y == 10'd5)) fail_now("s_midscan_timeout");
        #2;
        rst_s = 1'b1;
        #1;
        check("s_async_pix_x", s_pix_x, 0);
        check("s_async_pix_y", s_pix_y, 0);
        check("s_async_hsync", s_hsync, 1);
        check("s_async_vsync", s_vsync, 1);
        check("s_async_video_on", s_video_on, 1);
        check("s_async_p_tick", s_p_tick, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("s_async_frame_cnt", s_frame_cnt, 0);
`endif
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        check("s_restart_hold_x", s_pix_x, 0);
        @(negedge clk);
        check("s_restart_x", s_pix_x, 1);
        check("s_restart_y", s_pix_y, 0);
      end
    join

    check("d_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
